// File: rtl/upcoin_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package upcoin_pkg;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    EMIT      = 2'd1,
    EMIT_PRE  = 2'd2,
    EMIT_LAST = 2'd3
  } padder_state_t;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_LANE    = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

endpackage

// File: rtl/upcoin_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit big-endian padded blocks.
// Optional status outputs (blocks_out, len_ovf) are enabled by defining UPCOIN_PADDER_STATUS_EN.
module upcoin_padder
  import upcoin_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block,
  output logic         block_valid,
  output logic         block_last,
  input  logic         block_ready,
  output logic         busy
`ifdef UPCOIN_PADDER_STATUS_EN
  ,
  output logic [15:0]  blocks_out,
  output logic         len_ovf
`endif
);

  padder_state_t    state, state_d;
  logic [5:0]       ptr;
  logic [LEN_W-1:0] byte_count;
  logic [LEN_W-1:0] count_inc;
  logic             pad80_pending;
  logic             take;
  logic             xfer;
  logic             last_fits;
  logic [63:0]      len_new;
  logic [63:0]      len_cur;

  assign in_ready    = (state == FILL);
  assign block_valid = (state != FILL);
  assign block_last  = (state == EMIT_LAST);
  assign busy        = (state != FILL) | (ptr != 6'd0);

  assign take      = in_valid & in_ready;
  assign xfer      = block_valid & block_ready;
  assign count_inc = byte_count + LEN_W'(1);
  // The final byte leaves room for the length field only when it lands in lanes 0..54.
  assign last_fits = (ptr < 6'(LEN_LANE - 1));
  assign len_new   = 64'({count_inc, 3'b000});
  assign len_cur   = 64'({byte_count, 3'b000});

  always_comb begin
    state_d = state;
    unique case (state)
      FILL: begin
        if (take) begin
          if (in_last)
            state_d = last_fits ? EMIT_LAST : EMIT_PRE;
          else if (ptr == 6'(BLOCK_BYTES - 1))
            state_d = EMIT;
        end
      end
      EMIT:      if (xfer) state_d = FILL;
      EMIT_PRE:  if (xfer) state_d = EMIT_LAST;
      EMIT_LAST: if (xfer) state_d = FILL;
      default:   state_d = FILL;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the per-lane loop below relies on the last write winning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      ptr           <= 6'd0;
      byte_count    <= '0;
      block         <= '0;
      pad80_pending <= 1'b0;
    end else begin
      state <= state_d;
      unique case (state)
        FILL: begin
          if (take) begin
            ptr        <= ptr + 6'd1;
            byte_count <= count_inc;
            // Lanes past ptr may hold an earlier message, so the last byte rewrites all of them.
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (i == int'(ptr))
                block[8*(BLOCK_BYTES-1-i) +: 8] <= in_data;
              else if (in_last && (i > int'(ptr)))
                block[8*(BLOCK_BYTES-1-i) +: 8] <= (i == int'(ptr) + 1) ? PAD_BYTE : 8'h00;
            end
            if (in_last && last_fits)
              block[63:0] <= len_new;
            if (in_last && (ptr == 6'(BLOCK_BYTES - 1)))
              pad80_pending <= 1'b1;
          end
        end
        EMIT: begin
          if (xfer) begin
            ptr   <= 6'd0;
            block <= '0;
          end
        end
        EMIT_PRE: begin
          if (xfer)
            block <= {(pad80_pending ? PAD_BYTE : 8'h00),
                      {((LEN_LANE - 1) * 8){1'b0}},
                      len_cur};
        end
        EMIT_LAST: begin
          if (xfer) begin
            ptr           <= 6'd0;
            byte_count    <= '0;
            pad80_pending <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UPCOIN_PADDER_STATUS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blocks_out <= 16'd0;
      len_ovf    <= 1'b0;
    end else begin
      if (xfer && (state == EMIT_LAST))
        blocks_out <= 16'd0;
      else if (xfer)
        blocks_out <= blocks_out + 16'd1;
      if (take && (byte_count == {LEN_W{1'b1}}))
        len_ovf <= 1'b1;
    end
  end
`endif

endmodule
